// File: rtl/hex_pager_pkg.sv
// Shared constants and helpers for the hex display pager: active-low 7-segment codes
// and the window/index width arithmetic.
package hex_pager_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Entry n sits at [n*8 +: 8]; all codes keep the dp (bit 7) off.
  localparam logic [127:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] seg7_lookup(input logic [3:0] nib);
    return SEG_TABLE[{nib, 3'b000} +: 8];
  endfunction

  function automatic int calc_wpc(input int data_w, input int num_digits);
    return ((data_w / 4) + num_digits - 1) / num_digits;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_nibble_dec.sv
// One hex digit: nibble to active-low {dp,g,f,e,d,c,b,a}, with forced blank and dp override.
module seg7_nibble_dec
  import hex_pager_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       dot_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  logic [7:0] code_s;

  // Blanking takes the glyph away but the dp may still light on a blank digit.
  always_comb begin
    if (blank_i) begin
      code_s = SEG_BLANK;
    end else begin
      code_s = seg7_lookup(nib_i);
    end
    seg_o = {code_s[7] & ~dot_i, code_s[6:0]};
  end

endmodule

// File: rtl/hex_display_pager.sv
// Pages NUM_CH debug channels across NUM_DIGITS active-low hex digits, manual or auto-scrolled.
// Define HEX_PAGER_LZB_EN for leading-zero blanking inside the current window.
module hex_display_pager
  import hex_pager_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 32,
  parameter int NUM_DIGITS = 6,
  parameter int SCROLL_DIV = 50000000
) (
  input  logic                                           CLK,
  input  logic                                           RST,
  input  logic                                           ADV,
  input  logic                                           MODE_AUTO,
  input  logic [NUM_CH*DATA_W-1:0]                       CH_DATA,
  output logic [NUM_DIGITS*8-1:0]                        nHEX,
  output logic [idx_w(NUM_CH)-1:0]                       CH_SEL,
  output logic [idx_w(calc_wpc(DATA_W, NUM_DIGITS))-1:0] WIN
);

  localparam int NIB      = DATA_W / 4;
  localparam int WPC      = calc_wpc(DATA_W, NUM_DIGITS);
  localparam int CH_W     = idx_w(NUM_CH);
  localparam int WIN_W    = idx_w(WPC);
  localparam int PS_W     = idx_w(SCROLL_DIV);
  localparam int WIN_BITS = NUM_DIGITS * 4;
  localparam int PAD_W    = WPC * WIN_BITS;

  logic [CH_W-1:0]         ch_q, ch_d;
  logic [WIN_W-1:0]        win_q, win_d;
  logic [PS_W-1:0]         ps_q, ps_d;
  logic [NUM_DIGITS*8-1:0] nhex_q, nhex_d;

  logic                    tick_s;
  logic                    adv_s;
  logic [DATA_W-1:0]       ch_word_s;
  logic [PAD_W-1:0]        word_pad_s;
  logic [WIN_BITS-1:0]     win_nibs_s;
  logic [NUM_DIGITS-1:0]   range_blank_s;
  logic [NUM_DIGITS-1:0]   lz_blank_s;
  logic                    marker_s;
`ifdef HEX_PAGER_LZB_EN
  logic                    zero_run_s;
`endif

  // Prescaler and channel/window stepping; a coincident ADV and tick is one step.
  always_comb begin
    tick_s = MODE_AUTO & (ps_q == PS_W'(SCROLL_DIV - 1));
    adv_s  = ADV | tick_s;
    if (!MODE_AUTO) begin
      ps_d = '0;
    end else if (tick_s) begin
      ps_d = '0;
    end else begin
      ps_d = ps_q + PS_W'(1);
    end
    ch_d  = ch_q;
    win_d = win_q;
    if (adv_s) begin
      if (win_q == WIN_W'(WPC - 1)) begin
        win_d = '0;
        if (ch_q == CH_W'(NUM_CH - 1)) begin
          ch_d = '0;
        end else begin
          ch_d = ch_q + CH_W'(1);
        end
      end else begin
        win_d = win_q + WIN_W'(1);
      end
    end else begin
      ch_d  = ch_q;
      win_d = win_q;
    end
  end

  // Window extraction: the channel word is zero-padded so the last partial window stays in range.
  always_comb begin
    ch_word_s  = CH_DATA[int'(ch_q) * DATA_W +: DATA_W];
    word_pad_s = PAD_W'(ch_word_s);
    win_nibs_s = word_pad_s[int'(win_q) * WIN_BITS +: WIN_BITS];
    marker_s   = (win_q != '0);
    for (int d = 0; d < NUM_DIGITS; d++) begin
      range_blank_s[d] = ((int'(win_q) * NUM_DIGITS + d) >= NIB);
    end
`ifdef HEX_PAGER_LZB_EN
    zero_run_s = 1'b1;
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      zero_run_s    = zero_run_s & (win_nibs_s[d*4 +: 4] == 4'h0);
      lz_blank_s[d] = zero_run_s & (d != 0);
    end
`else
    lz_blank_s = '0;
`endif
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    seg7_nibble_dec u_dec (
      .nib_i   (win_nibs_s[g*4 +: 4]),
      .dot_i   ((g == NUM_DIGITS - 1) ? marker_s : 1'b0),
      .blank_i (range_blank_s[g] | lz_blank_s[g]),
      .seg_o   (nhex_d[g*8 +: 8])
    );
  end

  // State and display registers; the display lags the paging state by one cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ch_q   <= '0;
      win_q  <= '0;
      ps_q   <= '0;
      nhex_q <= '1;
    end else begin
      ch_q   <= ch_d;
      win_q  <= win_d;
      ps_q   <= ps_d;
      nhex_q <= nhex_d;
    end
  end

  assign nHEX   = nhex_q;
  assign CH_SEL = ch_q;
  assign WIN    = win_q;

endmodule

// File: tb/tb_hex_display_pager.sv
// Self-checking bench for hex_display_pager: directed steps plus random traffic against a
// position-based reference model. Expectations follow HEX_PAGER_LZB_EN when it is defined.
module tb_hex_display_pager;

  localparam int NUM_CH     = 4;
  localparam int DATA_W     = 32;
  localparam int NUM_DIGITS = 6;
  localparam int SCROLL_DIV = 4;
  localparam int NIB        = 8;
  localparam int WPC        = 2;

  logic                          CLK = 1'b0;
  logic                          RST;
  logic                          ADV;
  logic                          MODE_AUTO;
  logic [NUM_CH*DATA_W-1:0]      CH_DATA;
  logic [NUM_DIGITS*8-1:0]       nHEX;
  logic [1:0]                    CH_SEL;
  logic [0:0]                    WIN;

  int errors = 0;
  int checks = 0;
  int pos_m  = 0;
  int ps_m   = 0;
  logic [47:0] nhex_m = '1;
  logic [7:0]  segs [16];
  int walk_ch  [8];
  int walk_win [8];

  hex_display_pager #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .NUM_DIGITS(NUM_DIGITS), .SCROLL_DIV(SCROLL_DIV)
  ) dut (
    .CLK(CLK), .RST(RST), .ADV(ADV), .MODE_AUTO(MODE_AUTO),
    .CH_DATA(CH_DATA), .nHEX(nHEX), .CH_SEL(CH_SEL), .WIN(WIN)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Display for channel/window straight from the digit-to-nibble rule.
  function automatic logic [47:0] exp_disp(input int ch, input int win, input logic [127:0] data);
    logic [31:0] w;
    logic [47:0] r;
    logic [7:0]  code;
    int idx, hi, nib;
    w  = data[ch*32 +: 32];
    hi = 0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      idx = win * NUM_DIGITS + d;
      if (idx < NIB && ((w >> (4 * idx)) & 32'hF) != 32'h0) hi = d;
    end
    for (int d = 0; d < NUM_DIGITS; d++) begin
      idx = win * NUM_DIGITS + d;
      if (idx >= NIB) begin
        code = 8'hFF;
      end else begin
        nib  = int'((w >> (4 * idx)) & 32'hF);
        code = segs[nib];
      end
`ifdef HEX_PAGER_LZB_EN
      if (d > hi) code = 8'hFF;
`endif
      if (d == NUM_DIGITS - 1 && win != 0) code[7] = 1'b0;
      r[d*8 +: 8] = code;
    end
    return r;
  endfunction

  // One clock: update the model with the inputs seen at the edge, then compare.
  task automatic cycle();
    bit tick;
    @(posedge CLK);
    if (RST) begin
      pos_m  = 0;
      ps_m   = 0;
      nhex_m = '1;
    end else begin
      nhex_m = exp_disp(pos_m / WPC, pos_m % WPC, CH_DATA);
      tick   = MODE_AUTO && (ps_m == SCROLL_DIV - 1);
      ps_m   = (!MODE_AUTO || tick) ? 0 : ps_m + 1;
      if (ADV || tick) pos_m = (pos_m + 1) % (NUM_CH * WPC);
    end
    #1;
    check("ch_sel", 64'(CH_SEL), 64'(pos_m / WPC));
    check("win", 64'(WIN), 64'(pos_m % WPC));
    check("nhex", 64'(nHEX), 64'(nhex_m));
  endtask

  task automatic do_reset();
    RST = 1'b1;
    cycle();
    RST = 1'b0;
  endtask

  initial begin
    segs = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    walk_ch  = '{0, 1, 1, 2, 2, 3, 3, 0};
    walk_win = '{1, 0, 1, 0, 1, 0, 1, 0};
    RST       = 1'b1;
    ADV       = 1'b0;
    MODE_AUTO = 1'b0;
    for (int k = 0; k < NUM_CH; k++) CH_DATA[k*32 +: 32] = $urandom;
    CH_DATA[31:0] = 32'h1234ABCD;

    // Reset state, then the first window of channel 0.
    cycle();
    cycle();
    check("rst_nhex", 64'(nHEX), 64'hFFFF_FFFF_FFFF);
    check("rst_ch", 64'(CH_SEL), 64'd0);
    check("rst_win", 64'(WIN), 64'd0);
    RST = 1'b0;
    cycle();
    check("win0_digits", 64'(nHEX), 64'hB0_99_88_83_C6_A1);

    // One manual advance shows the partial window with the marker dp.
    ADV = 1'b1;
    cycle();
    ADV = 1'b0;
    check("adv_win", 64'(WIN), 64'd1);
    cycle();
    check("win1_digits", 64'(nHEX), 64'h7F_FF_FF_FF_F9_A4);

    // Eight advances walk every channel/window and wrap.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ADV = 1'b1;
      cycle();
      ADV = 1'b0;
      check("walk_ch", 64'(CH_SEL), 64'(walk_ch[i]));
      check("walk_win", 64'(WIN), 64'(walk_win[i]));
      cycle();
    end

    // Auto scroll: ADV on a tick is a single step; dropping MODE_AUTO restarts the count.
    do_reset();
    MODE_AUTO = 1'b1;
    repeat (3) cycle();
    ADV = 1'b1;
    cycle();
    ADV = 1'b0;
    check("coinc_ch", 64'(CH_SEL), 64'd0);
    check("coinc_win", 64'(WIN), 64'd1);
    cycle();
    MODE_AUTO = 1'b0;
    cycle();
    MODE_AUTO = 1'b1;
    repeat (3) cycle();
    check("restart_hold_win", 64'(WIN), 64'd1);
    cycle();
    check("restart_tick_ch", 64'(CH_SEL), 64'd1);
    check("restart_tick_win", 64'(WIN), 64'd0);

    // Reset in the middle of a scroll at channel 2, window 1.
    MODE_AUTO = 1'b0;
    do_reset();
    ADV = 1'b1;
    repeat (5) cycle();
    ADV = 1'b0;
    check("mid_ch", 64'(CH_SEL), 64'd2);
    check("mid_win", 64'(WIN), 64'd1);
    MODE_AUTO = 1'b1;
    ADV       = 1'b1;
    RST       = 1'b1;
    cycle();
    check("midrst_ch", 64'(CH_SEL), 64'd0);
    check("midrst_win", 64'(WIN), 64'd0);
    check("midrst_nhex", 64'(nHEX), 64'hFFFF_FFFF_FFFF);
    ADV       = 1'b0;
    RST       = 1'b0;
    MODE_AUTO = 1'b0;

    // Zero handling in window 0.
    do_reset();
    CH_DATA[31:0] = 32'h0000_0F00;
    cycle();
`ifdef HEX_PAGER_LZB_EN
    check("lzb_0f00", 64'(nHEX), 64'hFF_FF_FF_8E_C0_C0);
`else
    check("zeros_0f00", 64'(nHEX), 64'hC0_C0_C0_8E_C0_C0);
`endif
    CH_DATA[31:0] = 32'h0;
    cycle();
`ifdef HEX_PAGER_LZB_EN
    check("lzb_zero", 64'(nHEX), 64'hFF_FF_FF_FF_FF_C0);
`else
    check("zeros_zero", 64'(nHEX), 64'hC0_C0_C0_C0_C0_C0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      ADV       = ($urandom_range(3) == 0);
      MODE_AUTO = ($urandom_range(7) != 0);
      RST       = ($urandom_range(59) == 0);
      if ($urandom_range(4) == 0) begin
        for (int k = 0; k < NUM_CH; k++) CH_DATA[k*32 +: 32] = $urandom >> $urandom_range(31);
      end
      cycle();
    end
    RST = 1'b0;
    ADV = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
